// File: rtl/writeback_stage.sv
// RV32I writeback stage: MEM/WB register, result select, load alignment, trap and retire count.
// Optional feature macro: WB_BYPASS_EN adds a sticky copy of the last committed write for RAW bypass.
module writeback_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Enb,
   input  logic              i_Valid,
   output logic              o_Ready,
   input  logic              i_Flush,
   input  logic              i_Reg_Write,
   input  logic [ADDR_W-1:0] iv_Rd,
   input  logic [1:0]        iv_Wb_Sel,
   input  logic [2:0]        iv_Funct3,
   input  logic [DATA_W-1:0] iv_Alu_Result,
   input  logic [DATA_W-1:0] iv_Mem_Data,
   input  logic [DATA_W-1:0] iv_Pc_Plus4,
   input  logic [DATA_W-1:0] iv_Imm,
   output logic              oW_Enb,
   output logic [ADDR_W-1:0] ov_Write_R,
   output logic [DATA_W-1:0] ov_Write_Data,
   output logic              o_Misaligned,
   output logic [31:0]       ov_Retired,
`ifdef WB_BYPASS_EN
   output logic              o_Fwd_Valid,
   output logic [ADDR_W-1:0] ov_Fwd_R,
   output logic [DATA_W-1:0] ov_Fwd_Data,
`endif
   output logic [1:0]        ov_Dbg_State
);

   // Handshake: an instruction transfers on a rising edge where i_Enb, i_Valid and
   // o_Ready are high and i_Flush is low; o_Ready drops only while trapped.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_TRAP  = 2'd2
   } state_t;

   state_t              r_State;
   logic                r_Ready;
   logic                r_Misaligned;
   logic                r_WEnb;
   logic [ADDR_W-1:0]   r_Write_R;
   logic [DATA_W-1:0]   r_Write_Data;
   logic [31:0]         r_Retired;

   logic                w_Accept;
   logic [1:0]          w_Off;
   logic [7:0]          w_Byte;
   logic [15:0]         w_Half;
   logic [DATA_W-1:0]   w_Load_Data;
   logic                w_Load_Fault;
   logic                w_Trap;
   logic [DATA_W-1:0]   w_Result;
   logic                w_Do_Write;

   assign w_Accept   = i_Enb & i_Valid & r_Ready & ~i_Flush;
   assign w_Off      = iv_Alu_Result[1:0];
   assign w_Do_Write = i_Reg_Write & (iv_Rd != '0);

   always_comb begin
      w_Byte = iv_Mem_Data[7:0];
      case (w_Off)
         2'd0:    w_Byte = iv_Mem_Data[7:0];
         2'd1:    w_Byte = iv_Mem_Data[15:8];
         2'd2:    w_Byte = iv_Mem_Data[23:16];
         default: w_Byte = iv_Mem_Data[31:24];
      endcase
      w_Half = w_Off[1] ? iv_Mem_Data[31:16] : iv_Mem_Data[15:0];
   end

   always_comb begin
      w_Load_Data  = '0;
      w_Load_Fault = 1'b0;
      case (iv_Funct3)
         3'b000: w_Load_Data = {{24{w_Byte[7]}}, w_Byte};
         3'b001: begin
            w_Load_Data  = {{16{w_Half[15]}}, w_Half};
            w_Load_Fault = w_Off[0];
         end
         3'b010: begin
            w_Load_Data  = iv_Mem_Data;
            w_Load_Fault = (w_Off != 2'd0);
         end
         3'b100: w_Load_Data = {24'd0, w_Byte};
         3'b101: begin
            w_Load_Data  = {16'd0, w_Half};
            w_Load_Fault = w_Off[0];
         end
         default: w_Load_Fault = 1'b1;
      endcase
   end

   // Only loads can trap; the funct3 field is ignored for the other selects.
   assign w_Trap = (iv_Wb_Sel == 2'b01) & w_Load_Fault;

   always_comb begin
      w_Result = iv_Alu_Result;
      case (iv_Wb_Sel)
         2'b00:   w_Result = iv_Alu_Result;
         2'b01:   w_Result = w_Load_Data;
         2'b10:   w_Result = iv_Pc_Plus4;
         default: w_Result = iv_Imm;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_State      <= S_IDLE;
         r_Ready      <= 1'b1;
         r_Misaligned <= 1'b0;
         r_WEnb       <= 1'b0;
         r_Write_R    <= '0;
         r_Write_Data <= '0;
         r_Retired    <= '0;
      end else if (i_Enb) begin
         r_WEnb <= 1'b0;
         case (r_State)
            S_IDLE, S_WRITE: begin
               if (w_Accept && w_Trap) begin
                  r_State      <= S_TRAP;
                  r_Ready      <= 1'b0;
                  r_Misaligned <= 1'b1;
               end else if (w_Accept) begin
                  r_State   <= S_WRITE;
                  r_WEnb    <= w_Do_Write;
                  r_Retired <= r_Retired + 32'd1;
                  if (w_Do_Write) begin
                     r_Write_R    <= iv_Rd;
                     r_Write_Data <= w_Result;
                  end
               end else begin
                  r_State <= S_IDLE;
               end
            end
            S_TRAP: begin
               if (i_Flush) begin
                  r_State      <= S_IDLE;
                  r_Ready      <= 1'b1;
                  r_Misaligned <= 1'b0;
               end
            end
            default: begin
               r_State      <= S_IDLE;
               r_Ready      <= 1'b1;
               r_Misaligned <= 1'b0;
            end
         endcase
      end else begin
         // Frozen: only the one-cycle write strobe is allowed to fall.
         r_WEnb <= 1'b0;
      end
   end

   assign o_Ready       = r_Ready;
   assign o_Misaligned  = r_Misaligned;
   assign oW_Enb        = r_WEnb;
   assign ov_Write_R    = r_Write_R;
   assign ov_Write_Data = r_Write_Data;
   assign ov_Retired    = r_Retired;
   assign ov_Dbg_State  = r_State;

`ifdef WB_BYPASS_EN
   logic              r_Fwd_Valid;
   logic [ADDR_W-1:0] r_Fwd_R;
   logic [DATA_W-1:0] r_Fwd_Data;

   // Captures the write while the register file is taking it, so it is visible the cycle after.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_Fwd_Valid <= 1'b0;
         r_Fwd_R     <= '0;
         r_Fwd_Data  <= '0;
      end else if (r_WEnb) begin
         r_Fwd_Valid <= 1'b1;
         r_Fwd_R     <= r_Write_R;
         r_Fwd_Data  <= r_Write_Data;
      end
   end

   assign o_Fwd_Valid = r_Fwd_Valid;
   assign ov_Fwd_R    = r_Fwd_R;
   assign ov_Fwd_Data = r_Fwd_Data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; also covers the WB_BYPASS_EN outputs when defined.
module tb_writeback_stage;

   logic        i_Clk = 1'b0;
   logic        i_Rst, i_Enb, i_Valid, i_Flush, i_Reg_Write;
   logic [4:0]  iv_Rd;
   logic [1:0]  iv_Wb_Sel;
   logic [2:0]  iv_Funct3;
   logic [31:0] iv_Alu_Result, iv_Mem_Data, iv_Pc_Plus4, iv_Imm;
   logic        o_Ready, oW_Enb, o_Misaligned;
   logic [4:0]  ov_Write_R;
   logic [31:0] ov_Write_Data, ov_Retired;
   logic [1:0]  ov_Dbg_State;
`ifdef WB_BYPASS_EN
   logic        o_Fwd_Valid;
   logic [4:0]  ov_Fwd_R;
   logic [31:0] ov_Fwd_Data;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_ret = 0;

   writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enb(i_Enb), .i_Valid(i_Valid), .o_Ready(o_Ready),
      .i_Flush(i_Flush), .i_Reg_Write(i_Reg_Write), .iv_Rd(iv_Rd), .iv_Wb_Sel(iv_Wb_Sel),
      .iv_Funct3(iv_Funct3), .iv_Alu_Result(iv_Alu_Result), .iv_Mem_Data(iv_Mem_Data),
      .iv_Pc_Plus4(iv_Pc_Plus4), .iv_Imm(iv_Imm), .oW_Enb(oW_Enb), .ov_Write_R(ov_Write_R),
      .ov_Write_Data(ov_Write_Data), .o_Misaligned(o_Misaligned), .ov_Retired(ov_Retired),
`ifdef WB_BYPASS_EN
      .o_Fwd_Valid(o_Fwd_Valid), .ov_Fwd_R(ov_Fwd_R), .ov_Fwd_Data(ov_Fwd_Data),
`endif
      .ov_Dbg_State(ov_Dbg_State)
   );

   always #5 i_Clk = ~i_Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents one instruction for one edge, then samples 1 time unit after that edge.
   task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem);
      i_Reg_Write   = rw;
      iv_Rd         = rd;
      iv_Wb_Sel     = sel;
      iv_Funct3     = f3;
      iv_Alu_Result = alu;
      iv_Mem_Data   = mem;
      i_Valid       = 1'b1;
      @(posedge i_Clk);
      #1;
      i_Valid = 1'b0;
   endtask

   task automatic idle_cycle();
      i_Valid = 1'b0;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic test_reset();
      i_Rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_Enb = 1'($urandom_range(0, 1));  i_Valid = 1'($urandom_range(0, 1));
         i_Flush = 1'($urandom_range(0, 1)); i_Reg_Write = 1'($urandom_range(0, 1));
         iv_Rd = 5'($urandom_range(0, 31)); iv_Wb_Sel = 2'($urandom_range(0, 3));
         iv_Funct3 = 3'($urandom_range(0, 7)); iv_Alu_Result = $urandom;
         iv_Mem_Data = $urandom; iv_Pc_Plus4 = $urandom; iv_Imm = $urandom;
         @(posedge i_Clk);
         #1;
      end
      n_tests++; if (oW_Enb !== 1'b0) begin n_fail++; $display("FAIL reset_wenb: got %b exp 0", oW_Enb); end
      n_tests++; if (ov_Write_R !== 5'd0) begin n_fail++; $display("FAIL reset_r: got %0d exp 0", ov_Write_R); end
      n_tests++; if (ov_Write_Data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", ov_Write_Data); end
      n_tests++; if (o_Misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b exp 0", o_Misaligned); end
      n_tests++; if (ov_Retired !== 32'd0) begin n_fail++; $display("FAIL reset_ret: got %h exp 0", ov_Retired); end
      n_tests++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", o_Ready); end
`ifdef WB_BYPASS_EN
      n_tests++; if (o_Fwd_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd: got %b exp 0", o_Fwd_Valid); end
`endif
      i_Rst = 1'b0; i_Enb = 1'b1; i_Valid = 1'b0; i_Flush = 1'b0;
      iv_Pc_Plus4 = 32'h0000_2004; iv_Imm = 32'hABCD_E000;
      exp_ret = 0;
   endtask

   task automatic test_alu();
      send(1'b1, 5'd10, 2'b00, 3'b000, 32'd123456789, 32'h0);
      exp_ret++;
      n_tests++; if (oW_Enb !== 1'b1) begin n_fail++; $display("FAIL alu_wenb: got %b exp 1", oW_Enb); end
      n_tests++; if (ov_Write_R !== 5'd10) begin n_fail++; $display("FAIL alu_r: got %0d exp 10", ov_Write_R); end
      n_tests++; if (ov_Write_Data !== 32'd123456789) begin n_fail++; $display("FAIL alu_data: got %0d exp 123456789", ov_Write_Data); end
      n_tests++; if (ov_Retired !== 32'd1) begin n_fail++; $display("FAIL alu_ret: got %0d exp 1", ov_Retired); end
      idle_cycle();
      n_tests++; if (oW_Enb !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle: got %b exp 0", oW_Enb); end
      n_tests++; if (ov_Retired !== 32'd1) begin n_fail++; $display("FAIL alu_ret_hold: got %0d exp 1", ov_Retired); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3_t  [8];
      logic [1:0]  off_t [8];
      logic [1:0]  sel_t [8];
      logic [31:0] exp_t [8];
      f3_t = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000};
      off_t = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      sel_t = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
      exp_t = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                32'h0000_7F01, 32'h80FF_7F01, 32'h0000_2004, 32'hABCD_E000};
      for (int i = 0; i < 8; i++) begin
         send(1'b1, 5'(i + 1), sel_t[i], f3_t[i], {30'h400, off_t[i]}, 32'h80FF_7F01);
         exp_ret++;
         n_tests++;
         if (oW_Enb !== 1'b1 || ov_Write_R !== 5'(i + 1) || ov_Write_Data !== exp_t[i])
         begin
            n_fail++;
            $display("FAIL load_%0d: got en=%b r=%0d d=%h exp en=1 r=%0d d=%h",
                     i, oW_Enb, ov_Write_R, ov_Write_Data, i + 1, exp_t[i]);
         end
      end
      n_tests++; if (ov_Retired !== exp_ret) begin n_fail++; $display("FAIL load_ret: got %0d exp %0d", ov_Retired, exp_ret); end
      idle_cycle();
   endtask

   task automatic test_trap();
      logic [2:0] f3_t  [3];
      logic [1:0] off_t [3];
      f3_t  = '{3'b010, 3'b001, 3'b011};
      off_t = '{2'd2, 2'd1, 2'd0};
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 5'd3, 2'b01, f3_t[i], {30'h400, off_t[i]}, 32'h1234_5678);
         n_tests++;
         if (o_Misaligned !== 1'b1 || o_Ready !== 1'b0 || oW_Enb !== 1'b0 || ov_Retired !== exp_ret)
         begin
            n_fail++;
            $display("FAIL trap_%0d: got mis=%b rdy=%b en=%b ret=%0d exp mis=1 rdy=0 en=0 ret=%0d",
                     i, o_Misaligned, o_Ready, oW_Enb, ov_Retired, exp_ret);
         end
         // A legal instruction offered while trapped must not be taken.
         send(1'b1, 5'd4, 2'b00, 3'b000, 32'h55, 32'h0);
         n_tests++;
         if (o_Misaligned !== 1'b1 || oW_Enb !== 1'b0 || ov_Retired !== exp_ret) begin
            n_fail++;
            $display("FAIL trap_hold_%0d: got mis=%b en=%b ret=%0d exp mis=1 en=0 ret=%0d",
                     i, o_Misaligned, oW_Enb, ov_Retired, exp_ret);
         end
         i_Flush = 1'b1;
         idle_cycle();
         i_Flush = 1'b0;
         n_tests++;
         if (o_Misaligned !== 1'b0 || o_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_flush_%0d: got mis=%b rdy=%b exp mis=0 rdy=1", i, o_Misaligned, o_Ready);
         end
      end
   endtask

   task automatic test_x0_and_flush();
      send(1'b1, 5'd0, 2'b00, 3'b000, 32'h77, 32'h0);
      exp_ret++;
      n_tests++; if (oW_Enb !== 1'b0) begin n_fail++; $display("FAIL x0_wenb: got %b exp 0", oW_Enb); end
      n_tests++; if (ov_Retired !== exp_ret) begin n_fail++; $display("FAIL x0_ret: got %0d exp %0d", ov_Retired, exp_ret); end
      send(1'b0, 5'd7, 2'b00, 3'b000, 32'h88, 32'h0);
      exp_ret++;
      n_tests++;
      if (oW_Enb !== 1'b0 || ov_Retired !== exp_ret) begin
         n_fail++; $display("FAIL nowrite: got en=%b ret=%0d exp en=0 ret=%0d", oW_Enb, ov_Retired, exp_ret);
      end
      i_Flush = 1'b1;
      send(1'b1, 5'd9, 2'b00, 3'b000, 32'h99, 32'h0);
      i_Flush = 1'b0;
      n_tests++;
      if (oW_Enb !== 1'b0 || ov_Retired !== exp_ret) begin
         n_fail++; $display("FAIL flush_valid: got en=%b ret=%0d exp en=0 ret=%0d", oW_Enb, ov_Retired, exp_ret);
      end
   endtask

   task automatic test_enable();
      send(1'b1, 5'd12, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0);
      exp_ret++;
      i_Enb = 1'b0;
      send(1'b1, 5'd13, 2'b00, 3'b000, 32'hCAFE_0002, 32'h0);
      n_tests++;
      if (oW_Enb !== 1'b0 || ov_Write_R !== 5'd12 || ov_Write_Data !== 32'hCAFE_0001 || ov_Retired !== exp_ret)
      begin
         n_fail++;
         $display("FAIL enb_freeze: got en=%b r=%0d d=%h ret=%0d exp en=0 r=12 d=cafe0001 ret=%0d",
                  oW_Enb, ov_Write_R, ov_Write_Data, ov_Retired, exp_ret);
      end
      i_Enb = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] data_t [3];
      data_t = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 5'(20 + i), 2'b00, 3'b000, data_t[i], 32'h0);
         exp_ret++;
         n_tests++;
         if (oW_Enb !== 1'b1 || ov_Write_R !== 5'(20 + i) || ov_Write_Data !== data_t[i] || ov_Retired !== exp_ret)
         begin
            n_fail++;
            $display("FAIL b2b_%0d: got en=%b r=%0d d=%h ret=%0d exp en=1 r=%0d d=%h ret=%0d",
                     i, oW_Enb, ov_Write_R, ov_Write_Data, ov_Retired, 20 + i, data_t[i], exp_ret);
         end
      end
      idle_cycle();
   endtask

   task automatic test_wrap();
      force dut.r_Retired = 32'hFFFF_FFFF;
      @(negedge i_Clk);
      release dut.r_Retired;
      idle_cycle();
      n_tests++; if (ov_Retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h exp ffffffff", ov_Retired); end
      send(1'b1, 5'd6, 2'b00, 3'b000, 32'h6, 32'h0);
      exp_ret = 32'd0;
      n_tests++; if (ov_Retired !== exp_ret) begin n_fail++; $display("FAIL wrap: got %h exp 0", ov_Retired); end
      idle_cycle();
   endtask

`ifdef WB_BYPASS_EN
   task automatic test_bypass();
      send(1'b1, 5'd5, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0);
      idle_cycle();
      n_tests++;
      if (o_Fwd_Valid !== 1'b1 || ov_Fwd_R !== 5'd5 || ov_Fwd_Data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL fwd: got v=%b r=%0d d=%h exp v=1 r=5 d=deadbeef", o_Fwd_Valid, ov_Fwd_R, ov_Fwd_Data);
      end
      send(1'b1, 5'd0, 2'b00, 3'b000, 32'h1, 32'h0);
      send(1'b0, 5'd8, 2'b00, 3'b000, 32'h2, 32'h0);
      idle_cycle();
      n_tests++;
      if (o_Fwd_Valid !== 1'b1 || ov_Fwd_R !== 5'd5 || ov_Fwd_Data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL fwd_hold: got v=%b r=%0d d=%h exp v=1 r=5 d=deadbeef", o_Fwd_Valid, ov_Fwd_R, ov_Fwd_Data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_trap();
      test_x0_and_flush();
      test_enable();
      test_back_to_back();
      test_wrap();
`ifdef WB_BYPASS_EN
      test_bypass();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
